harris_nms: RTL and testbench

HARRIS_NMS -- requirements
Module: harris_nms

---
 rtl/harris_pkg.sv | 18 +
 rtl/harris_nms_if.sv | 29 ++
 rtl/harris_line_buffer.sv | 46 ++++
 rtl/harris_nms.sv | 157 +++++++++++++++
 tb/tb_harris_nms.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/harris_pkg.sv
// Shared types and helpers for the Harris corner non-maximum-suppression block.
package harris_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam logic MODE_THR = 1'b0;
  localparam logic MODE_NMS = 1'b1;

  // Samples between a center pixel and the newest sample of its window.
  function automatic int unsigned nms_delay(input int unsigned r, input int unsigned w);
    return r * w + r;
  endfunction

endpackage

// File: rtl/harris_nms_if.sv
// Streaming response input and per-pixel corner result bus.
interface harris_nms_if #(
  parameter int unsigned RESP_W = 32,
  parameter int unsigned X_W    = 8,
  parameter int unsigned Y_W    = 8,
  parameter int unsigned CNT_W  = 16
);
  logic signed [RESP_W-1:0] resp_in;
  logic                     valid_in;
  logic                     in_ready;
  logic signed [RESP_W-1:0] threshold;
  logic                     mode;
  logic                     valid_out;
  logic                     is_corner;
  logic [X_W-1:0]           x_out;
  logic [Y_W-1:0]           y_out;
  logic [CNT_W-1:0]         corner_count;
  logic                     frame_done;

  modport master (
    output resp_in, valid_in, threshold, mode,
    input  in_ready, valid_out, is_corner, x_out, y_out, corner_count, frame_done
  );

  modport slave (
    input  resp_in, valid_in, threshold, mode,
    output in_ready, valid_out, is_corner, x_out, y_out, corner_count, frame_done
  );
endinterface

// File: rtl/harris_line_buffer.sv
// 2R line memories plus a (2R+1)x(2R+1) window; win[2R][2R] is the newest sample.
module harris_line_buffer #(
  parameter int unsigned IMG_WIDTH = 256,
  parameter int unsigned RESP_W    = 32,
  parameter int unsigned R         = 1,
  parameter int unsigned COL_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [COL_W-1:0]         col,
  input  logic signed [RESP_W-1:0] din,
  output logic signed [RESP_W-1:0] win [2*R+1][2*R+1]
);
  localparam int unsigned NL = 2 * R;
  localparam int unsigned WN = 2 * R + 1;

  logic signed [RESP_W-1:0] lb  [NL][IMG_WIDTH];
  logic signed [RESP_W-1:0] tap [WN];

  // Column of the incoming sample: lb[j] holds the sample j+1 lines back.
  always_comb begin
    for (int unsigned k = 0; k < NL; k++) tap[k] = lb[NL-1-k][col];
    tap[NL] = din;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      lb[0][col] <= din;
      for (int unsigned j = 1; j < NL; j++) lb[j][col] <= lb[j-1][col];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < WN; r++)
        for (int unsigned c = 0; c < WN; c++) win[r][c] <= '0;
    end else if (push) begin
      for (int unsigned r = 0; r < WN; r++) begin
        for (int unsigned c = 0; c < NL; c++) win[r][c] <= win[r][c+1];
        win[r][NL] <= tap[r];
      end
    end
  end

endmodule

// File: rtl/harris_nms.sv
// Thresholds a raster stream of Harris responses with optional non-maximum suppression.
module harris_nms
  import harris_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 256,
  parameter int unsigned IMG_HEIGHT = 256,
  parameter int unsigned RESP_W     = 32,
  parameter int unsigned R          = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  harris_nms_if.slave   bus
);
  localparam int unsigned X_W   = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned Y_W   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int unsigned D     = nms_delay(R, IMG_WIDTH);
  localparam int unsigned NPIX  = IMG_WIDTH * IMG_HEIGHT;
  localparam int unsigned IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int unsigned FL_W  = (D > 1) ? $clog2(D) : 1;
  localparam int unsigned WN    = 2 * R + 1;

  state_e                   state_q, state_nx;
  logic [IDX_W-1:0]         in_idx;
  logic [FL_W-1:0]          fl_cnt;
  logic [X_W-1:0]           wcol, ox, ex;
  logic [Y_W-1:0]           oy, ey;
  logic                     em_q, e_last, out_last;
  logic                     accept_c, push_c, emit_c, nms_ok_c, border_c, corner_c;
  logic signed [RESP_W-1:0] din_c;
  logic signed [RESP_W-1:0] win [WN][WN];

  assign accept_c = bus.valid_in & bus.in_ready;
  assign push_c   = accept_c | (state_q == ST_FLUSH);
  assign emit_c   = push_c & (state_q != ST_FILL);
  assign din_c    = (state_q == ST_FLUSH) ? '0 : bus.resp_in;

  harris_line_buffer #(
    .IMG_WIDTH (IMG_WIDTH),
    .RESP_W    (RESP_W),
    .R         (R),
    .COL_W     (X_W)
  ) u_lb (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_c),
    .col   (wcol),
    .din   (din_c),
    .win   (win)
  );

  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_FILL:  if (accept_c && in_idx == IDX_W'(D - 1))    state_nx = ST_RUN;
      ST_RUN:   if (accept_c && in_idx == IDX_W'(NPIX - 1)) state_nx = ST_FLUSH;
      ST_FLUSH: if (fl_cnt == FL_W'(D - 1))                 state_nx = ST_FILL;
      default:                                              state_nx = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FILL;
      bus.in_ready <= 1'b1;
    end else begin
      state_q      <= state_nx;
      bus.in_ready <= (state_nx != ST_FLUSH);
    end
  end

  // Input position, flush length and line-buffer column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_idx <= '0;
      fl_cnt <= '0;
      wcol   <= '0;
    end else begin
      if (accept_c)
        in_idx <= (in_idx == IDX_W'(NPIX - 1)) ? '0 : in_idx + IDX_W'(1);
      if (state_q == ST_FLUSH)
        fl_cnt <= (fl_cnt == FL_W'(D - 1)) ? '0 : fl_cnt + FL_W'(1);
      if (push_c)
        wcol <= (wcol == X_W'(IMG_WIDTH - 1)) ? '0 : wcol + X_W'(1);
    end
  end

  // Center coordinates travel alongside the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      em_q   <= 1'b0;
      e_last <= 1'b0;
      ex     <= '0;
      ey     <= '0;
      ox     <= '0;
      oy     <= '0;
    end else begin
      em_q <= emit_c;
      if (emit_c) begin
        ex     <= ox;
        ey     <= oy;
        e_last <= (ox == X_W'(IMG_WIDTH - 1)) && (oy == Y_W'(IMG_HEIGHT - 1));
        if (ox == X_W'(IMG_WIDTH - 1)) begin
          ox <= '0;
          oy <= (oy == Y_W'(IMG_HEIGHT - 1)) ? '0 : oy + Y_W'(1);
        end else begin
          ox <= ox + X_W'(1);
        end
      end
    end
  end

  // Ties go to the neighbour that comes first in raster order.
  always_comb begin
    nms_ok_c = 1'b1;
    for (int unsigned r = 0; r < WN; r++) begin
      for (int unsigned c = 0; c < WN; c++) begin
        if (r < R || (r == R && c < R)) begin
          if (win[R][R] <= win[r][c]) nms_ok_c = 1'b0;
        end else if (r != R || c != R) begin
          if (win[R][R] < win[r][c]) nms_ok_c = 1'b0;
        end
      end
    end
  end

  assign border_c = (ex < X_W'(R)) || (ex >= X_W'(IMG_WIDTH - R)) ||
                    (ey < Y_W'(R)) || (ey >= Y_W'(IMG_HEIGHT - R));
  assign corner_c = !border_c && (win[R][R] > bus.threshold) &&
                    ((bus.mode == MODE_THR) || nms_ok_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.valid_out    <= 1'b0;
      bus.is_corner    <= 1'b0;
      bus.x_out        <= '0;
      bus.y_out        <= '0;
      bus.corner_count <= '0;
      bus.frame_done   <= 1'b0;
      out_last         <= 1'b0;
    end else begin
      bus.valid_out  <= em_q;
      bus.is_corner  <= em_q & corner_c;
      out_last       <= em_q & e_last;
      bus.frame_done <= bus.valid_out & out_last;
      if (em_q) begin
        bus.x_out <= ex;
        bus.y_out <= ey;
        if (ex == '0 && ey == '0)
          bus.corner_count <= CNT_W'(corner_c);
        else if (corner_c && bus.corner_count != '1)
          bus.corner_count <= bus.corner_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_harris_nms.sv
// Directed frames on an 8x8 image with R=1, checked against hand-derived corner maps.
module tb_harris_nms;
  localparam int unsigned NP = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  harris_nms_if #(.RESP_W(32), .X_W(3), .Y_W(3), .CNT_W(16)) bif ();

  harris_nms #(
    .IMG_WIDTH  (8),
    .IMG_HEIGHT (8),
    .RESP_W     (32),
    .R          (1),
    .CNT_W      (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  int nvec = 0;
  int nerr = 0;
  int img [NP];

  int n_out = 0, n_ord = 0, n_cor = 0, n_fd = 0, n_rlow = 0;
  int exp_pos = 0, last_cx = 0, last_cy = 0;
  logic [63:0] got_map = '0;

  // Output monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pos = 0;
    end else begin
      if (bif.valid_out) begin
        n_out++;
        if ({bif.y_out, bif.x_out} != 6'(exp_pos)) n_ord++;
        got_map[{bif.y_out, bif.x_out}] = bif.is_corner;
        if (bif.is_corner) begin
          n_cor++;
          last_cx = int'(bif.x_out);
          last_cy = int'(bif.y_out);
        end
        exp_pos = (exp_pos + 1) % NP;
      end
      if (!bif.in_ready)  n_rlow++;
      if (bif.frame_done) n_fd++;
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_img(input int bg, input int p1, input int v1, input int p2, input int v2);
    for (int i = 0; i < NP; i++) img[i] = bg;
    if (p1 >= 0) img[p1] = v1;
    if (p2 >= 0) img[p2] = v2;
  endtask

  task automatic send_pixels(input int n, input bit gaps, input string tag);
    int p  = 0;
    int it = 0;
    while (p < n && it < 400) begin
      @(negedge clk);
      if (gaps && (it % 4 == 3)) begin
        bif.valid_in = 1'b0;
      end else begin
        bif.valid_in = 1'b1;
        bif.resp_in  = img[p];
        if (bif.in_ready) p++;
      end
      it++;
    end
    check({tag, ".sent"}, p, n);
  endtask

  task automatic run_frame(input string tag, input int thr, input bit md, input bit gaps,
                           input logic [63:0] exp_map);
    int o0, ord0, c0, fd0, r0, t;
    o0 = n_out; ord0 = n_ord; c0 = n_cor; fd0 = n_fd; r0 = n_rlow;
    @(negedge clk);
    bif.threshold = thr;
    bif.mode      = md;
    send_pixels(NP, gaps, tag);
    // Keep offering junk while the block flushes; it must not be consumed.
    t = 0;
    while (n_fd == fd0 && t < 100) begin
      @(negedge clk);
      bif.valid_in = !bif.in_ready;
      bif.resp_in  = 12345;
      t++;
    end
    bif.valid_in = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, ".outputs"},   n_out - o0, NP);
    check({tag, ".order"},     n_ord - ord0, 0);
    check({tag, ".map"},       longint'(got_map), longint'(exp_map));
    check({tag, ".corners"},   n_cor - c0, $countones(exp_map));
    check({tag, ".count"},     bif.corner_count, $countones(exp_map));
    check({tag, ".done"},      n_fd - fd0, 1);
    check({tag, ".rdy_low"},   n_rlow - r0, 9);
  endtask

  initial begin
    int fd0;
    bif.valid_in  = 1'b0;
    bif.resp_in   = 0;
    bif.threshold = 1000;
    bif.mode      = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.valid_out", bif.valid_out, 0);
    check("rst.is_corner", bif.is_corner, 0);
    check("rst.frame_done", bif.frame_done, 0);
    check("rst.count", bif.corner_count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.in_ready", bif.in_ready, 1);

    set_img(0, -1, 0, -1, 0);
    run_frame("zero", 1000, 1'b1, 1'b0, 64'h0);

    set_img(0, 36, 5000, -1, 0);
    run_frame("peak44", 1000, 1'b1, 1'b1, 64'h1 << 36);
    check("peak44.x", last_cx, 4);
    check("peak44.y", last_cy, 4);

    set_img(0, 24, 5000, -1, 0);
    run_frame("border.m1", 1000, 1'b1, 1'b0, 64'h0);
    run_frame("border.m0", 1000, 1'b0, 1'b0, 64'h0);

    set_img(0, 27, 5000, 28, 5000);
    run_frame("tie.m1", 1000, 1'b1, 1'b0, 64'h1 << 27);
    run_frame("tie.m0", 1000, 1'b0, 1'b0, (64'h1 << 27) | (64'h1 << 28));

    set_img(0, 36, 1000, -1, 0);
    run_frame("thr.eq", 1000, 1'b1, 1'b0, 64'h0);
    set_img(0, 36, 1001, -1, 0);
    run_frame("thr.gt", 1000, 1'b1, 1'b0, 64'h1 << 36);
    set_img(-100, 36, -5, -1, 0);
    run_frame("thr.neg", -10, 1'b1, 1'b0, 64'h1 << 36);

    // Abandon a frame after 20 pixels; (1,1) has just been reported as a corner.
    set_img(0, 9, 5000, -1, 0);
    bif.threshold = 1000;
    bif.mode      = 1'b1;
    fd0 = n_fd;
    send_pixels(20, 1'b0, "midrst");
    @(negedge clk);
    check("midrst.pre_valid", bif.valid_out, 1);
    check("midrst.pre_corner", bif.is_corner, 1);
    check("midrst.pre_count", bif.corner_count, 1);
    rst_n = 1'b0;
    #1;
    check("midrst.valid_out", bif.valid_out, 0);
    check("midrst.is_corner", bif.is_corner, 0);
    check("midrst.count", bif.corner_count, 0);
    check("midrst.x_out", bif.x_out, 0);
    bif.valid_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst.no_done", n_fd - fd0, 0);
    check("midrst.in_ready", bif.in_ready, 1);

    set_img(0, 36, 5000, -1, 0);
    run_frame("after_rst", 1000, 1'b1, 1'b0, 64'h1 << 36);
    check("after_rst.x", last_cx, 4);
    check("after_rst.y", last_cy, 4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
